if_fetch_align: RTL and testbench

IF_FETCH_ALIGN -- requirements
Module: if_fetch_align

---
 rtl/if_fetch_align_pkg.sv | 15 +
 rtl/if_fetch_align_if.sv | 10 +
 rtl/if_hw_buffer.sv | 50 +++++
 rtl/if_fetch_align.sv | 92 +++++++++
 tb/tb_if_fetch_align.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_align_pkg.sv
// rtl/if_fetch_align_pkg.sv - shared constants and RVC detection for the fetch aligner
package if_fetch_align_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] HW_INC    = 32'd2;
  localparam logic [31:0] WORD_INC  = 32'd4;

  typedef logic [1:0] hw_cnt_t;

  // A halfword starts a compressed instruction unless its two low bits are 11
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/if_fetch_align_if.sv
// rtl/if_fetch_align_if.sv - instruction-memory read bus between fetch aligner and memory
interface if_fetch_align_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;

  modport master (output o_imem_req, o_imem_addr, input i_imem_valid, i_imem_rdata);
  modport slave  (input o_imem_req, o_imem_addr, output i_imem_valid, i_imem_rdata);
endinterface

// File: rtl/if_hw_buffer.sv
// rtl/if_hw_buffer.sv - three-entry halfword FIFO with pop-0/1/2, push-0/1/2 and clear
module if_hw_buffer
  import if_fetch_align_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_clear,
  input  logic [1:0]  i_push_cnt,
  input  logic [15:0] i_push_lo,
  input  logic [15:0] i_push_hi,
  input  logic [1:0]  i_pop_cnt,
  output hw_cnt_t     o_count,
  output logic [15:0] o_hw0,
  output logic [15:0] o_hw1
);

  logic [2:0][15:0] mem_q, mem_d;
  hw_cnt_t          count_q, count_d;
  logic [1:0]       rem;

  // Pop by shifting toward entry 0, then append pushed halfwords behind the survivors
  always_comb begin
    rem     = count_q - i_pop_cnt;
    mem_d   = mem_q >> {i_pop_cnt, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      if (i_push_cnt != 2'd0 && 2'(i) == rem) begin
        mem_d[i] = i_push_lo;
      end else if (i_push_cnt == 2'd2 && 2'(i) == rem + 2'd1) begin
        mem_d[i] = i_push_hi;
      end
    end
    count_d = i_clear ? 2'd0 : rem + i_push_cnt;
  end

  // Storage and occupancy registers
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      mem_q   <= '0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_hw0   = mem_q[0];
  assign o_hw1   = mem_q[1];

endmodule

// File: rtl/if_fetch_align.sv
// rtl/if_fetch_align.sv - fetch unit aligning 16/32-bit instructions from a word memory
module if_fetch_align
  import if_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic                    i_clk,
  input  logic                    i_resetn,
  if_fetch_align_if.master        imem,
  input  logic                    i_stall,
  input  logic                    i_redirect,
  input  logic [31:0]             i_redirect_pc,
  output logic [31:0]             o_if_pc,
  output logic [31:0]             o_if_instr,
  output logic                    o_valid,
  output logic                    o_compress
);

  hw_cnt_t     count;
  logic [15:0] hw0, hw1;
  logic [31:0] head_pc, fetch_addr;
  logic        outstanding, discard, skip_low;
  logic        head_rvc, consume, accept;
  logic [1:0]  pop_cnt, push_cnt, left_cnt;
  logic [15:0] push_lo, push_hi;

  if_hw_buffer u_buf (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_clear    (i_redirect),
    .i_push_cnt (push_cnt),
    .i_push_lo  (push_lo),
    .i_push_hi  (push_hi),
    .i_pop_cnt  (pop_cnt),
    .o_count    (count),
    .o_hw0      (hw0),
    .o_hw1      (hw1)
  );

  // Presentation, consume, fetch-request and push decisions for this cycle
  always_comb begin
    head_rvc    = is_rvc(hw0);
    o_valid     = !i_redirect && (count >= 2'd2 || (count != 2'd0 && head_rvc));
    o_compress  = o_valid && head_rvc;
    o_if_pc     = head_pc;
    o_if_instr  = !o_valid ? NOP_INSTR : (head_rvc ? {16'h0000, hw0} : {hw1, hw0});
    consume     = o_valid && !i_stall;
    pop_cnt     = !consume ? 2'd0 : (head_rvc ? 2'd1 : 2'd2);
    left_cnt    = count - pop_cnt;
    imem.o_imem_req  = i_resetn && !i_redirect && !outstanding && left_cnt <= 2'd1;
    imem.o_imem_addr = fetch_addr;
    // A redirect empties the buffer, so any word returning in that cycle is stale
    accept      = imem.i_imem_valid && !discard && !i_redirect;
    push_cnt    = !accept ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
    push_lo     = skip_low ? imem.i_imem_rdata[31:16] : imem.i_imem_rdata[15:0];
    push_hi     = imem.i_imem_rdata[31:16];
  end

  // PC tracking, request bookkeeping, discard and skip-low flags
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      head_pc     <= RESET_PC;
      fetch_addr  <= RESET_PC & ~32'd3;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      skip_low    <= 1'b0;
    end else if (i_redirect) begin
      head_pc     <= i_redirect_pc & ~32'd1;
      fetch_addr  <= i_redirect_pc & ~32'd3;
      skip_low    <= i_redirect_pc[1];
      outstanding <= outstanding && !imem.i_imem_valid;
      discard     <= outstanding && !imem.i_imem_valid;
    end else begin
      if (consume) begin
        head_pc <= head_pc + (head_rvc ? HW_INC : WORD_INC);
      end
      if (imem.i_imem_valid) begin
        outstanding <= 1'b0;
        if (discard) begin
          discard <= 1'b0;
        end else begin
          skip_low <= 1'b0;
        end
      end
      if (imem.o_imem_req) begin
        outstanding <= 1'b1;
        fetch_addr  <= fetch_addr + WORD_INC;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_align.sv
// tb/tb_if_fetch_align.sv - self-checking bench for if_fetch_align
module tb_if_fetch_align;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_resetn = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_if_pc, o_if_instr;
  logic        o_valid, o_compress;

  if_fetch_align_if imem ();

  if_fetch_align #(.RESET_PC(RST_PC)) dut (
    .i_clk         (i_clk),
    .i_resetn      (i_resetn),
    .imem          (imem.master),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_if_pc       (o_if_pc),
    .o_if_instr    (o_if_instr),
    .o_valid       (o_valid),
    .o_compress    (o_compress)
  );

  always #5 i_clk = ~i_clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- memory model: in-order responses, configurable latency
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  bit auto_mem = 1'b0;
  bit all32 = 1'b0;
  int lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = a ^ (a >> 7) ^ 32'h6A09_E667;
    x = x * 32'h2545_F491;
    x = x ^ (x >> 15);
    if (all32) x = x | 32'h0003_0003;
    return x;
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // ---------------- program-order reference: walk memory from model_pc
  logic [31:0] model_pc = RST_PC;
  bit sb_on = 1'b0;
  int consumed = 0;
  bit prev_frozen = 1'b0;
  logic [31:0] prev_pc, prev_instr;
  logic prev_cmp;
  logic s_req, s_valid, s_cmp;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic tick();
    pend_t p;
    logic [15:0] h;
    logic exp_c;
    logic [31:0] exp_i;
    if (auto_mem) begin
      imem.i_imem_valid = 1'b0;
      imem.i_imem_rdata = 32'hDEAD_BEEF;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem.i_imem_valid = 1'b1;
        imem.i_imem_rdata = mem_word(p.addr);
      end
    end
    #1;
    s_req = imem.o_imem_req; s_addr = imem.o_imem_addr; s_valid = o_valid;
    s_pc = o_if_pc; s_instr = o_if_instr; s_cmp = o_compress;
    if (auto_mem && s_req) begin
      chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
      chk("one_outstanding", pend.size(), 32'd0);
      pend.push_back('{s_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
    end
    if (i_redirect) begin
      chk1("redirect_no_valid", s_valid, 1'b0);
      chk1("redirect_no_req", s_req, 1'b0);
    end
    if (!s_valid) begin
      chk("idle_instr_nop", s_instr, NOP);
      chk1("idle_compress", s_cmp, 1'b0);
    end
    if (prev_frozen && !i_redirect) begin
      chk1("stall_hold_valid", s_valid, 1'b1);
      chk("stall_hold_pc", s_pc, prev_pc);
      chk("stall_hold_instr", s_instr, prev_instr);
      chk1("stall_hold_cmp", s_cmp, prev_cmp);
    end
    if (sb_on && s_valid && !i_stall && !i_redirect) begin
      h = mem_hw(model_pc);
      exp_c = (h[1:0] != 2'b11);
      exp_i = exp_c ? {16'h0000, h} : {mem_hw(model_pc + 32'd2), h};
      chk("sb_pc", s_pc, model_pc);
      chk("sb_instr", s_instr, exp_i);
      chk1("sb_compress", s_cmp, exp_c);
      model_pc = model_pc + (exp_c ? 32'd2 : 32'd4);
      consumed++;
    end
    prev_frozen = s_valid && i_stall && !i_redirect;
    prev_pc = s_pc; prev_instr = s_instr; prev_cmp = s_cmp;
    if (i_redirect) model_pc = i_redirect_pc & ~32'd1;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_resetn = 1'b0; i_stall = 1'b0; i_redirect = 1'b0;
    imem.i_imem_valid = 1'b0;
    pend.delete();
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk("rst_instr", o_if_instr, NOP);
    chk1("rst_compress", o_compress, 1'b0);
    chk("rst_pc", o_if_pc, RST_PC);
    chk1("rst_req", imem.o_imem_req, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
    model_pc = RST_PC;
    prev_frozen = 1'b0;
  endtask

  task automatic run_until_valid(input string nm, input int lim);
    int n;
    n = 0;
    do begin tick(); n++; end while (!s_valid && n < lim);
    if (!s_valid) begin
      total_cnt++;
      $display("FAIL %s: no o_valid within %0d cycles", nm, lim);
    end
  endtask

  // ---------------- cycle vectors for the directed one-cycle-latency sequences
  typedef struct {
    bit rst; bit mv; logic [31:0] rdata;
    bit req; logic [31:0] addr; bit vld; logic [31:0] pc; logic [31:0] instr; bit cmp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    int c0, n;
    imem.i_imem_valid = 1'b0;
    imem.i_imem_rdata = '0;

    vecs.push_back('{1, 0, 32'h0,           0, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 1, 32'h00A0_0513,   0, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h4, 1, 32'h0, 32'h00A0_0513, 0});
    vecs.push_back('{0, 1, 32'h0000_4501,   0, 32'h0, 0, 32'h4, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h8, 1, 32'h4, 32'h0000_4501, 1});
    vecs.push_back('{1, 0, 32'h0,           0, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 1, 32'h0513_4501,   0, 32'h0, 0, 32'h0, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h4, 1, 32'h0, 32'h0000_4501, 1});
    vecs.push_back('{0, 1, 32'h0000_00A0,   0, 32'h0, 0, 32'h2, NOP,           0});
    vecs.push_back('{0, 0, 32'h0,           1, 32'h8, 1, 32'h2, 32'h00A0_0513, 0});
    vecs.push_back('{0, 0, 32'h0,           0, 32'h0, 1, 32'h6, 32'h0000_0000, 1});
    vecs.push_back('{0, 0, 32'h0,           0, 32'h0, 0, 32'h8, NOP,           0});

    @(negedge i_clk);
    foreach (vecs[k]) begin
      if (vecs[k].rst) begin
        do_reset();
      end else begin
        imem.i_imem_valid = vecs[k].mv;
        imem.i_imem_rdata = vecs[k].rdata;
        #1;
        chk1($sformatf("vec%0d_req", k), imem.o_imem_req, vecs[k].req);
        if (vecs[k].req) chk($sformatf("vec%0d_addr", k), imem.o_imem_addr, vecs[k].addr);
        chk1($sformatf("vec%0d_valid", k), o_valid, vecs[k].vld);
        chk($sformatf("vec%0d_pc", k), o_if_pc, vecs[k].pc);
        chk($sformatf("vec%0d_instr", k), o_if_instr, vecs[k].instr);
        chk1($sformatf("vec%0d_cmp", k), o_compress, vecs[k].cmp);
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
      end
    end

    auto_mem = 1'b1;
    sb_on = 1'b1;

    // redirect to a halfword-offset target before the first fetch
    do_reset();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0102;
    tick();
    i_redirect = 1'b0;
    tick();
    chk1("redir_req", s_req, 1'b1);
    chk("redir_addr", s_addr, 32'h0000_0100);
    run_until_valid("redir_wait", 20);
    chk("redir_first_pc", s_pc, 32'h0000_0102);

    // redirect while a 3-cycle request is in flight
    do_reset();
    lat_lo = 3; lat_hi = 3;
    tick();
    i_redirect = 1'b1; i_redirect_pc = 32'h0000_0200;
    tick();
    i_redirect = 1'b0;
    run_until_valid("stale_wait", 30);
    chk("stale_first_pc", s_pc, 32'h0000_0200);
    for (int i = 0; i < 20; i++) tick();

    // stall with only 32-bit instructions
    do_reset();
    all32 = 1'b1; lat_lo = 1; lat_hi = 1;
    i_stall = 1'b1;
    run_until_valid("stall_wait", 20);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("stall_req_off", s_req, 1'b0);
      chk("stall_pc", s_pc, RST_PC);
    end
    i_stall = 1'b0;
    c0 = consumed;
    for (int i = 0; i < 12; i++) tick();
    chk1("stall_release_progress", (consumed - c0) >= 3, 1'b1);
    all32 = 1'b0;

    // asynchronous reset while a request is outstanding
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 12; i++) tick();
    n = 0;
    while (pend.size() == 0 && n < 10) begin tick(); n++; end
    chk1("arst_outstanding", pend.size() != 0, 1'b1);
    #2;
    i_resetn = 1'b0;
    #1;
    chk1("arst_valid", o_valid, 1'b0);
    chk("arst_instr", o_if_instr, NOP);
    chk1("arst_cmp", o_compress, 1'b0);
    chk("arst_pc", o_if_pc, RST_PC);
    chk1("arst_req", imem.o_imem_req, 1'b0);
    pend.delete();
    imem.i_imem_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
    model_pc = RST_PC;
    prev_frozen = 1'b0;
    tick();
    chk1("arst_first_req", s_req, 1'b1);
    chk("arst_first_addr", s_addr, RST_PC);

    // randomized traffic against the program-order reference
    lat_lo = 1; lat_hi = 3;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      i_stall = ($urandom_range(99) < 30);
      i_redirect = ($urandom_range(99) < 4);
      if ($urandom_range(9) == 0) i_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
      else i_redirect_pc = 32'($urandom_range(1023));
      tick();
    end
    i_stall = 1'b0; i_redirect = 1'b0;
    chk1("random_progress", (consumed - c0) > 300, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
